uart_tx_scheduler: RTL and testbench

//  Sequences UART serial transmission off the per-bit tx tick from the baud rate generator.

---
 rtl/uart_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Purpose: buffers bytes in a small FIFO and frames them onto the UART tx line (start, 8 data LSB first, 1/2 stop).
// Latency: start bit goes low on the first tx tick at least one cycle after a byte lands in an idle, empty FIFO.
// Backpressure: wr_ready_o drops while the FIFO is full; a write offered then is dropped even if a pop occurs.
module uart_tx_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          tx_tick_i,
  input  logic                          tx_en_i,
  input  logic                          two_stop_i,
  input  logic                          wr_valid_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic                          wr_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          fifo_empty_o,
  output logic                          fifo_full_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push, pop;

  state_t            state_q, state_d;
  logic              tx_q, tx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              two_stop_q, two_stop_d;
  logic              can_start;

  assign fifo_empty_o = (count_q == '0);
  assign fifo_full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_count_o = count_q;
  assign wr_ready_o   = !fifo_full_o;
  // Readiness is taken from the registered count, so a pop cannot free a slot for a same-cycle write.
  assign push         = wr_valid_i && wr_ready_o;
  assign can_start    = tx_en_i && !fifo_empty_o;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != IDLE);

  // FIFO storage: data only, pointers carry the reset state.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= wr_data_i;
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame state register; the line idles high out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      two_stop_q <= two_stop_d;
    end
  end

  // Next-state and line value; everything advances only on a baud tick.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    two_stop_d = two_stop_q;
    pop        = 1'b0;
    if (tx_tick_i) begin
      case (state_q)
        IDLE: begin
          if (can_start) begin
            pop        = 1'b1;
            shift_d    = mem[rd_ptr_q];
            two_stop_d = two_stop_i;
            tx_d       = 1'b0;
            state_d    = START;
          end else begin
            tx_d = 1'b1;
          end
        end
        START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q == 3'(DATA_W - 1)) begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
          end else begin
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        STOP: begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
            tx_d       = 1'b1;
          end else if (can_start) begin
            // Back-to-back: the next start bit follows the last stop bit directly.
            pop        = 1'b1;
            shift_d    = mem[rd_ptr_q];
            two_stop_d = two_stop_i;
            tx_d       = 1'b0;
            state_d    = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose: directed bench for uart_tx_scheduler framing, FIFO limits, enable and reset behaviour.
// Latency: inputs change on the falling edge, outputs are sampled on the following falling edge.
// Backpressure: writes are offered for one cycle; the full-FIFO case holds wr_valid_i until a pop.
module tb_uart_tx_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       tx_tick_i;
  logic       tx_en_i;
  logic       two_stop_i;
  logic       wr_valid_i;
  logic [7:0] wr_data_i;
  logic       wr_ready_o;
  logic       tx_o;
  logic       busy_o;
  logic [3:0] fifo_count_o;
  logic       fifo_empty_o;
  logic       fifo_full_o;

  int   checks = 0;
  int   errors = 0;
  int   div = 0;
  logic tick_always = 1'b0;
  logic last_tick = 1'b0;

  uart_tx_scheduler #(.FIFO_DEPTH(8), .DATA_W(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tx_tick_i    (tx_tick_i),
    .tx_en_i      (tx_en_i),
    .two_stop_i   (two_stop_i),
    .wr_valid_i   (wr_valid_i),
    .wr_data_i    (wr_data_i),
    .wr_ready_o   (wr_ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o),
    .fifo_empty_o (fifo_empty_o),
    .fifo_full_o  (fifo_full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: tick every 16th cycle (or every cycle in continuous mode).
  task automatic cyc();
    tx_tick_i = tick_always || (div == 15);
    div = (div + 1) % 16;
    @(posedge clk_i);
    @(negedge clk_i);
    last_tick = tx_tick_i;
  endtask

  task automatic next_tick();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!last_tick && n < 40);
    if (!last_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: observed no tick in %0d cycles, expected one", n);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    cyc();
    wr_valid_i = 1'b0;
  endtask

  task automatic tick_chk(input string tag, input logic exp);
    next_tick();
    chk(tag, tx_o, exp);
    chk({tag, "_busy"}, busy_o, 1);
  endtask

  task automatic frame_rest(input string tag, input logic [7:0] d, input logic two);
    for (int i = 0; i < 8; i++) tick_chk(tag, d[i]);
    tick_chk({tag, "_stop"}, 1'b1);
    if (two) tick_chk({tag, "_stop2"}, 1'b1);
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic two);
    tick_chk({tag, "_start"}, 1'b0);
    frame_rest(tag, d, two);
  endtask

  task automatic idle_chk(input string tag);
    next_tick();
    chk({tag, "_idle_busy"}, busy_o, 0);
    chk({tag, "_idle_tx"}, tx_o, 1);
  endtask

  initial begin
    rst_i      = 1'b0;
    tx_tick_i  = 1'b0;
    tx_en_i    = 1'b0;
    two_stop_i = 1'b0;
    wr_valid_i = 1'b0;
    wr_data_i  = 8'h00;
    @(negedge clk_i);
    cyc();
    cyc();

    // Reset state
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_empty", fifo_empty_o, 1);
    chk("rst_full", fifo_full_o, 0);
    chk("rst_ready", wr_ready_o, 1);
    rst_i = 1'b1;
    cyc();

    // 0x55, one stop bit: 0,1,0,1,0,1,0,1,0,1 then idle
    tx_en_i = 1'b1;
    wr(8'h55);
    chk("f55_count_after_wr", fifo_count_o, 1);
    frame("f55", 8'h55, 1'b0);
    chk("f55_count", fifo_count_o, 0);
    idle_chk("f55");

    // 0xA3, two stop bits; two_stop_i dropped after the start bit must not shorten the frame
    two_stop_i = 1'b1;
    wr(8'hA3);
    tick_chk("fa3_start", 1'b0);
    two_stop_i = 1'b0;
    frame_rest("fa3", 8'hA3, 1'b1);
    idle_chk("fa3");

    // Fill FIFO with transmission disabled; 9th write dropped
    tx_en_i = 1'b0;
    for (int i = 0; i < 8; i++) wr(8'(8'h10 + i));
    chk("fill_full", fifo_full_o, 1);
    chk("fill_ready", wr_ready_o, 0);
    chk("fill_count", fifo_count_o, 8);
    wr(8'hEE);
    chk("fill_9th_count", fifo_count_o, 8);
    chk("fill_idle_busy", busy_o, 0);

    // Hold a write against the full FIFO through the popping tick: not taken
    tx_en_i    = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i  = 8'hEE;
    begin
      int n = 0;
      do begin
        cyc();
        n++;
      end while (!last_tick && n < 40);
    end
    wr_valid_i = 1'b0;
    chk("pop_full_count", fifo_count_o, 7);
    chk("pop_full_ready", wr_ready_o, 1);
    chk("b2b0_start", tx_o, 0);
    chk("b2b0_busy", busy_o, 1);
    frame_rest("b2b0", 8'h10, 1'b0);
    for (int f = 1; f < 8; f++) frame($sformatf("b2b%0d", f), 8'(8'h10 + f), 1'b0);
    idle_chk("b2b");
    chk("b2b_count", fifo_count_o, 0);

    // Drop tx_en_i during DATA of first of two bytes
    wr(8'h0F);
    wr(8'hE0);
    tick_chk("en_start", 1'b0);
    tick_chk("en_d0", 1'b1);
    tick_chk("en_d1", 1'b1);
    tx_en_i = 1'b0;
    tick_chk("en_d2", 1'b1);
    tick_chk("en_d3", 1'b1);
    tick_chk("en_d4", 1'b0);
    tick_chk("en_d5", 1'b0);
    tick_chk("en_d6", 1'b0);
    tick_chk("en_d7", 1'b0);
    tick_chk("en_stop", 1'b1);
    idle_chk("en_off");
    chk("en_off_count", fifo_count_o, 1);
    idle_chk("en_off2");

    // Async reset while bit 4 (a zero) of 0xE0 is on the line
    tx_en_i = 1'b1;
    tick_chk("ar_start", 1'b0);
    for (int i = 0; i < 5; i++) tick_chk("ar_bit", 1'b0);
    wr(8'h99);
    chk("ar_count_pre", fifo_count_o, 1);
    chk("ar_tx_pre", tx_o, 0);
    rst_i = 1'b0;
    #1;
    chk("ar_tx", tx_o, 1);
    chk("ar_count", fifo_count_o, 0);
    chk("ar_busy", busy_o, 0);
    chk("ar_empty", fifo_empty_o, 1);
    cyc();
    cyc();
    rst_i = 1'b1;
    idle_chk("ar_post1");
    idle_chk("ar_post2");
    wr(8'h81);
    frame("f81", 8'h81, 1'b0);
    idle_chk("f81");

    // Tick held high: one bit per clock
    tick_always = 1'b1;
    wr(8'hC5);
    frame("fc5", 8'hC5, 1'b0);
    idle_chk("fc5");
    chk("fc5_count", fifo_count_o, 0);
    tick_always = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
